// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the 4-digit display arbiter.
package display_pkg;

   localparam int unsigned DIGIT_W    = 7;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned SLICE_W    = DIGIT_W * NUM_DIGITS;

   // Arbiter state encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   typedef logic [DIGIT_W-1:0] seg_t;

   // Segment pattern with every segment off
   localparam seg_t SEG_BLANK = 7'h00;

   // One requester's display payload, digit_0 in the LSBs
   typedef struct packed {
      seg_t d3;
      seg_t d2;
      seg_t d1;
      seg_t d0;
   } digits_t;

   // All four digits dark
   function automatic digits_t blank_digits();
      digits_t d;
      d.d3 = SEG_BLANK;
      d.d2 = SEG_BLANK;
      d.d1 = SEG_BLANK;
      d.d0 = SEG_BLANK;
      return d;
   endfunction

   // Counter width for a 0..n-1 range, never narrower than one bit
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// Round-robin winner selection: first set request above rr_ptr, wrapping.
module rr_pick
   import display_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [PTR_W-1:0]   winner,
   output logic               any_req
);

   int unsigned idx;
   logic        found;

   // Scan rr_ptr+1 .. rr_ptr+NUM_REQ so the last owner is checked last
   always_comb begin
      winner  = '0;
      found   = 1'b0;
      idx     = 0;
      any_req = |req;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(rr_ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            winner = PTR_W'(idx);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/display_arbiter.sv
// Shares the 4-digit 7-segment display between requesters with
// round-robin ownership, a minimum dwell per owner and a blank gap.
module display_arbiter
   import display_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned HOLD_CYCLES  = 1000,
   parameter int unsigned BLANK_CYCLES = 50
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*SLICE_W-1:0] req_digits,
   output logic [NUM_REQ-1:0]         grant,
   output logic [DIGIT_W-1:0]         digit_0,
   output logic [DIGIT_W-1:0]         digit_1,
   output logic [DIGIT_W-1:0]         digit_2,
   output logic [DIGIT_W-1:0]         digit_3,
   output logic                       busy
);

   localparam int unsigned PTR_W   = cnt_w(NUM_REQ);
   localparam int unsigned HOLD_W  = cnt_w(HOLD_CYCLES);
   localparam int unsigned BLANK_W = cnt_w(BLANK_CYCLES);

   state_t               state;
   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     winner;
   logic                 any_req;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [BLANK_W-1:0]   blank_cnt;
   digits_t              disp;
   logic [SLICE_W-1:0]   slices [NUM_REQ];
   logic [NUM_REQ-1:0]   owner_oh;
   logic [NUM_REQ-1:0]   others;
   logic                 hold_done;
   logic                 blank_done;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   // Split the flat payload bus into one slice per requester
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         slices[i] = req_digits[i*SLICE_W +: SLICE_W];
      end
   end

   // The owner is always rr_ptr while SHOW is active
   assign owner_oh   = NUM_REQ'(1) << rr_ptr;
   assign others     = req & ~owner_oh;
   assign hold_done  = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
   assign blank_done = (blank_cnt == BLANK_W'(BLANK_CYCLES - 1));

   // Arbitration FSM with counters and registered grant/digit outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         grant     <= '0;
         disp      <= blank_digits();
         busy      <= 1'b0;
         hold_cnt  <= '0;
         blank_cnt <= '0;
         rr_ptr    <= PTR_W'(NUM_REQ - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state    <= ST_SHOW;
                  grant    <= NUM_REQ'(1) << winner;
                  rr_ptr   <= winner;
                  disp     <= digits_t'(slices[winner]);
                  hold_cnt <= '0;
                  busy     <= 1'b1;
               end else begin
                  grant <= '0;
                  disp  <= blank_digits();
                  busy  <= 1'b0;
               end
            end

            ST_SHOW: begin
               if (!hold_done) begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
                  if (req[rr_ptr]) begin
                     disp <= digits_t'(slices[rr_ptr]);
                  end
               end else if (|others) begin
                  state     <= ST_BLANK;
                  grant     <= '0;
                  disp      <= blank_digits();
                  blank_cnt <= '0;
               end else if (req[rr_ptr]) begin
                  disp <= digits_t'(slices[rr_ptr]);
               end else begin
                  state <= ST_IDLE;
                  grant <= '0;
                  disp  <= blank_digits();
                  busy  <= 1'b0;
               end
            end

            ST_BLANK: begin
               if (!blank_done) begin
                  blank_cnt <= blank_cnt + BLANK_W'(1);
               end else if (any_req) begin
                  state    <= ST_SHOW;
                  grant    <= NUM_REQ'(1) << winner;
                  rr_ptr   <= winner;
                  disp     <= digits_t'(slices[winner]);
                  hold_cnt <= '0;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
               grant <= '0;
               disp  <= blank_digits();
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign digit_0 = disp.d0;
   assign digit_1 = disp.d1;
   assign digit_2 = disp.d2;
   assign digit_3 = disp.d3;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter (NUM_REQ=4, HOLD_CYCLES=8, BLANK_CYCLES=2).
module tb_display_arbiter;

   logic         clk;
   logic         reset;
   logic [3:0]   req;
   logic [111:0] req_digits;
   logic [3:0]   grant;
   logic [6:0]   digit_0, digit_1, digit_2, digit_3;
   logic         busy;

   logic [27:0]  s0, s1, s2, s3;

   int n_checks;
   int n_fail;

   localparam logic [27:0] S0  = 28'h0123456;
   localparam logic [27:0] S1  = 28'h0654321;
   localparam logic [27:0] S2  = 28'h0ABCDEF;
   localparam logic [27:0] S3  = 28'h0FEDCBA;
   localparam logic [27:0] S2B = 28'h1234567;
   localparam logic [27:0] JNK = 28'h5A5A5A5;

   assign req_digits = {s3, s2, s1, s0};

   display_arbiter #(
      .NUM_REQ      (4),
      .HOLD_CYCLES  (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_digits (req_digits),
      .grant      (grant),
      .digit_0    (digit_0),
      .digit_1    (digit_1),
      .digit_2    (digit_2),
      .digit_3    (digit_3),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: count and report mismatches
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Compare all outputs against expected grant / digit word / busy
   task automatic check_out(input string tag, input logic [3:0] g, input logic [27:0] d, input logic b);
      check({tag, ".grant"},  32'(grant), 32'(g));
      check({tag, ".digits"}, 32'({digit_3, digit_2, digit_1, digit_0}), 32'(d));
      check({tag, ".busy"},   32'(busy), 32'(b));
   endtask

   // Advance one edge; outputs then reflect that edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 4'b0000;
      step();
      reset = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      req      = 4'b0000;
      s0 = S0; s1 = S1; s2 = S2; s3 = S3;

      // 1: idle after reset, no requests
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step();
         check_out("t1_idle", 4'b0000, 28'h0, 1'b0);
      end

      // 2: single requester, 1-cycle grant latency and live update
      do_reset();
      step();
      check_out("t2_pre", 4'b0000, 28'h0, 1'b0);
      req = 4'b0100;
      step();
      check_out("t2_grant", 4'b0100, S2, 1'b1);
      s2 = S2B;
      step();
      check_out("t2_live", 4'b0100, S2B, 1'b1);
      req = 4'b0000;
      s2  = S2;

      // 3: two requesters alternate with blank gaps
      do_reset();
      req = 4'b0011;
      for (int i = 0; i < 8; i++) begin
         step();
         check_out("t3_own0", 4'b0001, S0, 1'b1);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         check_out("t3_blank_a", 4'b0000, 28'h0, 1'b1);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         check_out("t3_own1", 4'b0010, S1, 1'b1);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         check_out("t3_blank_b", 4'b0000, 28'h0, 1'b1);
      end
      step();
      check_out("t3_own0_again", 4'b0001, S0, 1'b1);

      // 4: owner drops mid-dwell: frozen digits, held grant, then idle
      do_reset();
      req = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         step();
         check_out("t4_show", 4'b0001, S0, 1'b1);
      end
      req = 4'b0000;
      s0  = JNK;
      for (int i = 0; i < 5; i++) begin
         step();
         check_out("t4_frozen", 4'b0001, S0, 1'b1);
      end
      step();
      check_out("t4_idle", 4'b0000, 28'h0, 1'b0);
      s0 = S0;

      // 5: expired lone owner keeps display until another requester appears
      do_reset();
      req = 4'b1000;
      for (int i = 0; i < 10; i++) begin
         step();
         check_out("t5_own3", 4'b1000, S3, 1'b1);
      end
      req = 4'b1010;
      for (int i = 0; i < 2; i++) begin
         step();
         check_out("t5_blank", 4'b0000, 28'h0, 1'b1);
      end
      step();
      check_out("t5_own1", 4'b0010, S1, 1'b1);

      // 6: reset mid-SHOW clears outputs and restores pointer
      do_reset();
      req = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         step();
         check_out("t6_show", 4'b0100, S2, 1'b1);
      end
      reset = 1'b1;
      step();
      check_out("t6_reset", 4'b0000, 28'h0, 1'b0);
      reset = 1'b0;
      req   = 4'b1001;
      step();
      check_out("t6_regrant", 4'b0001, S0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
